// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared definitions for the instruction fetch unit.
//   NPC_SEQ/NPC_BR/NPC_J/NPC_JR : encodings of the npc_op next-PC select
//   PC_RESET                    : first fetch address after reset
//   PC_STEP                     : sequential instruction stride in bytes
//   br_offset()                 : sign-extended, word-scaled branch offset
package ifu_pkg;

  localparam logic [1:0]  NPC_SEQ  = 2'b00;
  localparam logic [1:0]  NPC_BR   = 2'b01;
  localparam logic [1:0]  NPC_J    = 2'b10;
  localparam logic [1:0]  NPC_JR   = 2'b11;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Branch displacement in bytes: imm16 is a signed word count.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// ifu_npc -- combinational next-PC selection for the fetch unit.
// Ports:
//   pc          in  32  current fetch PC
//   pc4_d       in  32  PC+4 of the instruction in ID (base for branch/jump)
//   npc_op      in   2  next-PC select (NPC_SEQ/NPC_BR/NPC_J/NPC_JR)
//   br          in   1  branch condition from the ID comparator
//   imm16       in  16  branch offset field
//   instr_index in  26  jump target field
//   ra          in  32  forwarded rs value for jr
//   npc         out 32  selected next PC (always word aligned)
//   taken       out  1  a redirect away from the sequential path is selected
module ifu_npc (
  input  logic [31:0] pc,
  input  logic [31:0] pc4_d,
  input  logic [1:0]  npc_op,
  input  logic        br,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] ra,
  output logic [31:0] npc,
  output logic        taken
);
  import ifu_pkg::*;

  logic [31:0] pc_seq_s;

  assign pc_seq_s = pc + PC_STEP;

  // Next-PC mux; all wrap-around arithmetic is plain modulo 2^32.
  always_comb begin
    npc   = pc_seq_s;
    taken = 1'b0;
    case (npc_op)
      NPC_SEQ: begin
        npc   = pc_seq_s;
        taken = 1'b0;
      end
      NPC_BR: begin
        if (br) begin
          npc   = pc4_d + br_offset(imm16);
          taken = 1'b1;
        end else begin
          npc   = pc_seq_s;
          taken = 1'b0;
        end
      end
      NPC_J: begin
        npc   = {pc4_d[31:28], instr_index, 2'b00};
        taken = 1'b1;
      end
      NPC_JR: begin
        // Low two bits of ra are dropped so the PC stays word aligned.
        npc   = ra & 32'hFFFF_FFFC;
        taken = 1'b1;
      end
      default: begin
        npc   = pc_seq_s;
        taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ifu.sv
// ifu -- instruction fetch unit: PC register and IF/ID pipeline register.
// Ports:
//   clk, reset   system clock (rising edge), asynchronous active-high reset
//   stall        freezes PC and IF/ID; any redirect waits for release
//   br, npc_op, imm16, instr_index, ra   next-PC controls from the ID stage
//   im_data      instruction memory read data for im_addr
//   im_addr      current fetch PC
//   instr_d      IF/ID instruction
//   pc4_d/pc8_d  PC+4 / PC+8 of the instruction held in IF/ID
// Build option: IFU_BR_FLUSH_EN -- when defined, the instruction fetched
// alongside a taken redirect is replaced by a nop bubble (instr_d = 0,
// pc4_d = 0); when undefined it is kept as the delay slot.
module ifu (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br,
  input  logic [1:0]  npc_op,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] ra,
  input  logic [31:0] im_data,
  output logic [31:0] im_addr,
  output logic [31:0] instr_d,
  output logic [31:0] pc4_d,
  output logic [31:0] pc8_d
);
  import ifu_pkg::*;

  logic [31:0] pc_r;
  logic [31:0] instr_d_r;
  logic [31:0] pc4_d_r;
  logic [31:0] npc_s;
  logic [31:0] pc_seq_s;
  logic        taken_s;

  assign pc_seq_s = pc_r + PC_STEP;

  ifu_npc u_npc (
    .pc          (pc_r),
    .pc4_d       (pc4_d_r),
    .npc_op      (npc_op),
    .br          (br),
    .imm16       (imm16),
    .instr_index (instr_index),
    .ra          (ra),
    .npc         (npc_s),
    .taken       (taken_s)
  );

`ifndef IFU_BR_FLUSH_EN
  // Delay-slot build keeps the fetched instruction, so taken is not needed.
  logic unused_taken_s;
  assign unused_taken_s = taken_s;
`endif

  // PC and IF/ID registers; stall holds everything including the redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r      <= PC_RESET;
      instr_d_r <= 32'h0000_0000;
      pc4_d_r   <= 32'h0000_0000;
    end else if (!stall) begin
      pc_r <= npc_s;
`ifdef IFU_BR_FLUSH_EN
      if (taken_s) begin
        instr_d_r <= 32'h0000_0000;
        pc4_d_r   <= 32'h0000_0000;
      end else begin
        instr_d_r <= im_data;
        pc4_d_r   <= pc_seq_s;
      end
`else
      instr_d_r <= im_data;
      pc4_d_r   <= pc_seq_s;
`endif
    end
  end

  assign im_addr = pc_r;
  assign instr_d = instr_d_r;
  assign pc4_d   = pc4_d_r;
  assign pc8_d   = pc4_d_r + PC_STEP;

endmodule

// File: tb/tb_ifu.sv
// tb_ifu -- self-checking bench for ifu, directed scenarios plus a random
// run compared against a behavioural model of the fetch rules.
module tb_ifu;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br;
  logic [1:0]  npc_op;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] ra;
  logic [31:0] im_data;
  logic [31:0] im_addr;
  logic [31:0] instr_d;
  logic [31:0] pc4_d;
  logic [31:0] pc8_d;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state: fetch PC and IF/ID contents.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0001;
  endfunction

  assign im_data = mem_word(im_addr);

  ifu dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br          (br),
    .npc_op      (npc_op),
    .imm16       (imm16),
    .instr_index (instr_index),
    .ra          (ra),
    .im_data     (im_data),
    .im_addr     (im_addr),
    .instr_d     (instr_d),
    .pc4_d       (pc4_d),
    .pc8_d       (pc8_d)
  );

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic cycle(input logic s, input logic [1:0] op, input logic b,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] r);
    logic        taken_v;
    logic [31:0] n_pc;
    stall = s; npc_op = op; br = b; imm16 = imm; instr_index = idx; ra = r;
    taken_v = (op == 2'd1 && b) || op == 2'd2 || op == 2'd3;
    if (op == 2'd1 && b)  n_pc = m_pc4 + 32'(int'($signed(imm)) * 4);
    else if (op == 2'd2)  n_pc = (m_pc4 & 32'hF000_0000) + ({6'd0, idx} * 32'd4);
    else if (op == 2'd3)  n_pc = r - (r % 32'd4);
    else                  n_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
    if (!s) begin
`ifdef IFU_BR_FLUSH_EN
      if (taken_v) begin
        m_instr = 32'd0;
        m_pc4   = 32'd0;
      end else begin
        m_instr = mem_word(m_pc);
        m_pc4   = m_pc + 32'd4;
      end
`else
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
`endif
      m_pc = n_pc;
    end
  endtask

  task automatic seq_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0; npc_op = 2'd0; br = 1'b0;
    #1;
    m_pc = 32'h0000_3000; m_instr = 32'd0; m_pc4 = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; br = 1'b0; npc_op = 2'd0;
    imm16 = 16'd0; instr_index = 26'd0; ra = 32'd0;
    m_pc = 32'h0000_3000; m_instr = 32'd0; m_pc4 = 32'd0;
    #2;
    n_vec++; if (im_addr !== 32'h0000_3000) begin n_err++; $display("FAIL reset_pc got %h want %h", im_addr, 32'h0000_3000); end
    n_vec++; if (instr_d !== 32'd0) begin n_err++; $display("FAIL reset_instr got %h want %h", instr_d, 32'd0); end
    n_vec++; if (pc4_d !== 32'd0) begin n_err++; $display("FAIL reset_pc4 got %h want %h", pc4_d, 32'd0); end
    n_vec++; if (pc8_d !== 32'd4) begin n_err++; $display("FAIL reset_pc8 got %h want %h", pc8_d, 32'd4); end
    @(negedge clk); reset = 1'b0; #1;
    seq_cycles(3);
    // Mid-run reset with a jump pending, asserted away from any clock edge.
    npc_op = 2'd2; instr_index = 26'h0ABCDE;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_vec++; if (im_addr !== 32'h0000_3000) begin n_err++; $display("FAIL async_reset_pc got %h want %h", im_addr, 32'h0000_3000); end
    n_vec++; if (instr_d !== 32'd0) begin n_err++; $display("FAIL async_reset_instr got %h want %h", instr_d, 32'd0); end
    n_vec++; if (pc4_d !== 32'd0) begin n_err++; $display("FAIL async_reset_pc4 got %h want %h", pc4_d, 32'd0); end
    @(negedge clk); reset = 1'b0; npc_op = 2'd0; #1;
    m_pc = 32'h0000_3000; m_instr = 32'd0; m_pc4 = 32'd0;
    n_vec++; if (im_addr !== 32'h0000_3000) begin n_err++; $display("FAIL first_fetch got %h want %h", im_addr, 32'h0000_3000); end
    seq_cycles(1);
    n_vec++; if (im_addr !== 32'h0000_3004) begin n_err++; $display("FAIL post_reset_pc got %h want %h", im_addr, 32'h0000_3004); end
    n_vec++; if (instr_d !== mem_word(32'h0000_3000)) begin n_err++; $display("FAIL post_reset_instr got %h want %h", instr_d, mem_word(32'h0000_3000)); end
  endtask

  task automatic test_branch();
    apply_reset();
    seq_cycles(2);
    n_vec++; if (pc4_d !== 32'h0000_3008) begin n_err++; $display("FAIL br_setup_pc4 got %h want %h", pc4_d, 32'h0000_3008); end
    cycle(1'b0, 2'd1, 1'b1, 16'hFFFE, 26'd0, 32'd0);
    n_vec++; if (im_addr !== 32'h0000_3000) begin n_err++; $display("FAIL br_taken got %h want %h", im_addr, 32'h0000_3000); end
    apply_reset();
    seq_cycles(2);
    cycle(1'b0, 2'd1, 1'b0, 16'hFFFE, 26'd0, 32'd0);
    n_vec++; if (im_addr !== 32'h0000_300C) begin n_err++; $display("FAIL br_not_taken got %h want %h", im_addr, 32'h0000_300C); end
  endtask

  task automatic test_delay_slot();
    apply_reset();
    seq_cycles(2);
    cycle(1'b0, 2'd1, 1'b1, 16'h0010, 26'd0, 32'd0);
    n_vec++; if (im_addr !== 32'h0000_3048) begin n_err++; $display("FAIL slot_target got %h want %h", im_addr, 32'h0000_3048); end
`ifdef IFU_BR_FLUSH_EN
    n_vec++; if (instr_d !== 32'd0) begin n_err++; $display("FAIL flush_instr got %h want %h", instr_d, 32'd0); end
    n_vec++; if (pc4_d !== 32'd0) begin n_err++; $display("FAIL flush_pc4 got %h want %h", pc4_d, 32'd0); end
`else
    n_vec++; if (instr_d !== mem_word(32'h0000_3008)) begin n_err++; $display("FAIL slot_instr got %h want %h", instr_d, mem_word(32'h0000_3008)); end
    n_vec++; if (pc4_d !== 32'h0000_300C) begin n_err++; $display("FAIL slot_pc4 got %h want %h", pc4_d, 32'h0000_300C); end
`endif
  endtask

  task automatic test_jump();
    apply_reset();
    seq_cycles(4);
    n_vec++; if (pc4_d !== 32'h0000_3010) begin n_err++; $display("FAIL j_setup_pc4 got %h want %h", pc4_d, 32'h0000_3010); end
    cycle(1'b0, 2'd2, 1'b0, 16'd0, 26'h0000C40, 32'd0);
    n_vec++; if (im_addr !== 32'h0000_3100) begin n_err++; $display("FAIL j_target got %h want %h", im_addr, 32'h0000_3100); end
    cycle(1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h0000_3207);
    n_vec++; if (im_addr !== 32'h0000_3204) begin n_err++; $display("FAIL jr_target got %h want %h", im_addr, 32'h0000_3204); end
  endtask

  task automatic test_stall();
    logic [31:0] pc_hold, instr_hold, pc4_hold, want;
    apply_reset();
    seq_cycles(3);
    pc_hold = m_pc; instr_hold = m_instr; pc4_hold = m_pc4;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd2, 1'b0, 16'd0, 26'h0123456, 32'd0);
      n_vec++; if (im_addr !== pc_hold) begin n_err++; $display("FAIL stall_pc[%0d] got %h want %h", i, im_addr, pc_hold); end
      n_vec++; if (instr_d !== instr_hold) begin n_err++; $display("FAIL stall_instr[%0d] got %h want %h", i, instr_d, instr_hold); end
      n_vec++; if (pc4_d !== pc4_hold) begin n_err++; $display("FAIL stall_pc4[%0d] got %h want %h", i, pc4_d, pc4_hold); end
    end
    want = (pc4_hold & 32'hF000_0000) + 32'h0123456 * 32'd4;
    cycle(1'b0, 2'd2, 1'b0, 16'd0, 26'h0123456, 32'd0);
    n_vec++; if (im_addr !== want) begin n_err++; $display("FAIL stall_release got %h want %h", im_addr, want); end
  endtask

  task automatic test_wrap();
    apply_reset();
    cycle(1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'hFFFF_FFFC);
    n_vec++; if (im_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got %h want %h", im_addr, 32'hFFFF_FFFC); end
    seq_cycles(1);
    n_vec++; if (im_addr !== 32'd0) begin n_err++; $display("FAIL wrap_pc got %h want %h", im_addr, 32'd0); end
    n_vec++; if (pc4_d !== 32'd0) begin n_err++; $display("FAIL wrap_pc4 got %h want %h", pc4_d, 32'd0); end
    n_vec++; if (pc8_d !== 32'd4) begin n_err++; $display("FAIL wrap_pc8 got %h want %h", pc8_d, 32'd4); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(3) == 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
            16'($urandom), 26'($urandom), $urandom);
      n_vec++; if (im_addr !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h want %h", i, im_addr, m_pc); end
      n_vec++; if (instr_d !== m_instr) begin n_err++; $display("FAIL rnd_instr[%0d] got %h want %h", i, instr_d, m_instr); end
      n_vec++; if (pc4_d !== m_pc4) begin n_err++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, pc4_d, m_pc4); end
      n_vec++; if (pc8_d !== m_pc4 + 32'd4) begin n_err++; $display("FAIL rnd_pc8[%0d] got %h want %h", i, pc8_d, m_pc4 + 32'd4); end
      n_vec++; if (im_addr[1:0] !== 2'b00) begin n_err++; $display("FAIL rnd_align[%0d] got %b want 00", i, im_addr[1:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_delay_slot();
    test_jump();
    test_stall();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
